wm_stream_embed: RTL and testbench
==================================

# wm_stream_embed

Streaming watermark-embedding stage for the colour-image pipeline: it takes RGB pixel beats of LANES pixels each, as produced by the image reader, and one watermark bit per pixel. Per lane it embeds the bit into the pixel LSBs under a per-frame mode and reports the pixel luminance average. It adds valid/ready flow control, frame-geometry checking and a frame-done pulse. It sits between the image source and the image writer/BMP dump.

## Interface
- DW, 8: bits per colour channel.
- LANES, 2: pixels per beat.
- WIDTH, 768: pixels per row; must be a multiple of LANES.
- HEIGHT, 512: rows per frame.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cfg_mode  in  2  embed mode: 0 bypass, 1 LSB of R,G,B, 2 LSB of B only, 3 parity-in-G.
- in_valid / in_ready  in / out  1  input beat handshake.
- in_sof  in  1  first beat of frame.
- in_eol  in  1  last beat of row.
- in_data  in  LANES*3*DW  lane 0 in the LSBs; each pixel packed {R,G,B}, with B in the low DW bits.
- wm_valid / wm_ready  in / out  1  watermark handshake.
- wm_data  in  LANES  watermark bit per lane.
- out_valid / out_ready  out / in  1  output beat handshake.
- out_sof, out_eol, out_eof  out  1  frame markers aligned with out_data.
- out_data  out  LANES*3*DW  embedded pixels, same packing as in_data.
- out_avg  out  LANES*DW  per-lane floor((R+G+B)/3) of the input pixel, before embedding.
- done  out  1  one-cycle pulse after the out_eof beat is accepted.
- err  out  1  sticky geometry error.

## Operation
- Active mode: cfg_mode is latched when an in_sof beat is accepted and holds for the whole frame. Before the first sof the active mode is 0.
- Beat acceptance:
  - Active mode 0: a beat is accepted when in_valid && in_ready. wm_ready is held at 0.
  - Active mode nonzero: in_data and wm_data are accepted together, and only when in_valid && wm_valid && pipeline space. in_ready = wm_ready = space && in_valid && wm_valid. in_ready must never depend combinationally on out_valid.
- Per lane, with wm bit w:
  - mode 1: R[0]=G[0]=B[0]=w.
  - mode 2: B[0]=w.
  - mode 3: G[0]=w^R[0]^B[0], so that R[0]^G[0]^B[0]=w.
  - mode 0: pixel passes unchanged.
- Average: out_avg is exact floor division by 3 of a DW+2-bit sum, for any DW.
- Geometry tracking: beat column counter 0..WIDTH/LANES-1 and row counter 0..HEIGHT-1.
  - in_eol must arrive exactly at the last column. If it is missing or early: set err, force the counters to end of row, continue.
  - in_sof at a non-zero position: set err, restart the counters at 0,0 and treat the beat as the start of a new frame.
  - err clears on the next correctly placed sof, i.e. one at 0,0.
- out_eof is generated internally on the beat at the last column of the last row. The counters wrap to 0,0 after that beat.
- Reset, including mid-frame: pipeline flushed, counters 0, active mode 0, err 0.

## Timing
- Two-stage pipeline:
  - S1 registers the pixels, wm bits, markers and the channel sum.
  - S2 registers the embedded data and the avg.
- Latency: a beat accepted at cycle N appears on out_* at N+2 when out_ready stays high.
- Throughput: 1 beat/cycle.
- Stall rules:
  - S2 holds while out_valid && !out_ready.
  - S1 advances into S2 whenever S2 is empty or draining.
  - Pipeline space exists when S1 is empty or S1 is advancing.
  - out_data and markers stay stable while stalled.
- done: asserted the cycle after the out_eof beat is accepted.
- Reset values: all outputs 0, including in_ready and wm_ready. in_ready rises no earlier than the first edge after reset release.

## Structure
- Package wm_pkg holds:
  - the mode enum (WM_BYPASS, WM_LSB_RGB, WM_LSB_B, WM_PARITY_G);
  - pixel field offset constants;
  - the div3 function.
- Sub-module wm_lane_embed: one instance per lane, combinational embed plus avg for a single pixel.
- The top level holds handshakes, counters and pipeline registers.

## Test plan
Small bench configuration: WIDTH=4, HEIGHT=2, LANES=2, DW=8.

1. Mode 1, pixel R=0x10 G=0x21 B=0x33, w=1 -> out 0x11,0x21,0x33; avg 0x21; output 2 cycles after accept.
2. Mode 2, same pixel, w=0 -> B=0x32, R and G unchanged. Mode 0 with wm_valid=0 -> beats still flow, wm_ready stays 0.
3. Mode 3, same pixel: w=1 -> G=0x20; w=0 -> G=0x21.
4. Full 4-beat frame with random out_ready and wm_valid gaps -> no loss or duplication; out_eol on beats 1 and 3; out_eof on beat 3; done pulses once; err=0.
5. in_eol on beat 0, then a stray sof on beat 1 -> err set, counters resync; the next clean frame clears err.
6. HRESETn low mid-frame with S1 and S2 full -> all outputs 0 immediately; the next frame processes normally.

Source files
------------

// File: rtl/wm_stream_embed_pkg.sv
// Shared types and helpers for the watermark-embedding stream stage.
// Defines the embed-mode enum, the pixel channel layout and an exact divide-by-three.
package wm_pkg;

    typedef enum logic [1:0] {
        WM_BYPASS   = 2'd0,
        WM_LSB_RGB  = 2'd1,
        WM_LSB_B    = 2'd2,
        WM_PARITY_G = 2'd3
    } wm_mode_e;

    // Channel slots inside a packed {R,G,B} pixel, counted from the LSB in units of DW.
    localparam int CH_B   = 0;
    localparam int CH_G   = 1;
    localparam int CH_R   = 2;
    localparam int PIX_CH = 3;

    // Exact floor(x/3); the 64-bit argument covers any channel-sum width up to DW = 62.
    function automatic logic [63:0] div3(input logic [63:0] x);
        return x / 64'd3;
    endfunction

endpackage

// File: rtl/wm_stream_embed_if.sv
// Handshake bundle for wm_stream_embed: pixel beats in, watermark bits in,
// embedded beats out, plus the per-frame mode and status flags.
interface wm_stream_embed_if #(
    parameter int DW    = 8,
    parameter int LANES = 2
);
    logic [1:0]              cfg_mode;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sof;
    logic                    in_eol;
    logic [LANES*3*DW-1:0]   in_data;
    logic                    wm_valid;
    logic                    wm_ready;
    logic [LANES-1:0]        wm_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sof;
    logic                    out_eol;
    logic                    out_eof;
    logic [LANES*3*DW-1:0]   out_data;
    logic [LANES*DW-1:0]     out_avg;
    logic                    done;
    logic                    err;

    // The upstream source / downstream sink side.
    modport master (
        output cfg_mode, in_valid, in_sof, in_eol, in_data, wm_valid, wm_data, out_ready,
        input  in_ready, wm_ready, out_valid, out_sof, out_eol, out_eof, out_data, out_avg,
               done, err
    );

    // The embedding stage itself.
    modport slave (
        input  cfg_mode, in_valid, in_sof, in_eol, in_data, wm_valid, wm_data, out_ready,
        output in_ready, wm_ready, out_valid, out_sof, out_eol, out_eof, out_data, out_avg,
               done, err
    );
endinterface

// File: rtl/wm_lane_embed.sv
// Single-pixel watermark embed and luminance average, purely combinational.
// The channel sum arrives precomputed so the average is one divide-by-three.
module wm_lane_embed
    import wm_pkg::*;
#(
    parameter int DW = 8
) (
    input  wm_mode_e                mode,
    input  logic [PIX_CH*DW-1:0]    pix,
    input  logic                    w,
    input  logic [DW+1:0]           sum,
    output logic [PIX_CH*DW-1:0]    pix_out,
    output logic [DW-1:0]           avg
);
    localparam int R_LSB = CH_R * DW;
    localparam int G_LSB = CH_G * DW;
    localparam int B_LSB = CH_B * DW;

    always_comb begin
        // NOTE: pix_out takes the unmodified pixel first so every path assigns it and no latch is inferred.
        pix_out = pix;
        case (mode)
            WM_LSB_RGB: begin
                pix_out[R_LSB] = w;
                pix_out[G_LSB] = w;
                pix_out[B_LSB] = w;
            end
            WM_LSB_B:    pix_out[B_LSB] = w;
            // G LSB chosen so that the XOR of the three LSBs equals the watermark bit.
            WM_PARITY_G: pix_out[G_LSB] = w ^ pix[R_LSB] ^ pix[B_LSB];
            default:     pix_out = pix;
        endcase
    end

    assign avg = DW'(div3(64'(sum)));

endmodule

// File: rtl/wm_stream_embed.sv
// Two-stage streaming watermark embedder: handshakes, frame-geometry tracking,
// per-frame mode latching and the S1 (capture + sum) / S2 (embed + avg) pipeline.
module wm_stream_embed
    import wm_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LANES  = 2,
    parameter int WIDTH  = 768,   // must be a multiple of LANES
    parameter int HEIGHT = 512
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    wm_stream_embed_if.slave bus
);
    localparam int PW   = PIX_CH * DW;
    localparam int BW   = LANES * PW;
    localparam int SW   = DW + 2;
    localparam int COLS = WIDTH / LANES;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    logic                    run;
    wm_mode_e                active_mode;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic                    err_q;
    logic                    done_q;

    logic                    s1_valid;
    logic [BW-1:0]           s1_data;
    logic [LANES-1:0]        s1_wm;
    logic [LANES-1:0][SW-1:0] s1_sum;
    wm_mode_e                s1_mode;
    logic                    s1_sof, s1_eol, s1_eof;

    logic                    s2_valid;
    logic [BW-1:0]           s2_data;
    logic [LANES*DW-1:0]     s2_avg;
    logic                    s2_sof, s2_eol, s2_eof;

    logic                    s2_free, space, accept;
    wm_mode_e                beat_mode;
    logic [CW-1:0]           pos_col;
    logic [RW-1:0]           pos_row;
    logic                    at_origin, last_col, row_end, frame_end, geo_bad;
    logic [LANES-1:0][SW-1:0] in_sum;
    logic [BW-1:0]           emb_data;
    logic [LANES*DW-1:0]     emb_avg;

    // Flow control: space depends on registered state and out_ready only.
    always_comb begin
        s2_free      = !s2_valid || bus.out_ready;
        space        = run && (!s1_valid || s2_free);
        beat_mode    = bus.in_sof ? wm_mode_e'(bus.cfg_mode) : active_mode;
        bus.in_ready = 1'b0;
        bus.wm_ready = 1'b0;
        if (beat_mode == WM_BYPASS) begin
            bus.in_ready = space;
        end else begin
            bus.in_ready = space && bus.in_valid && bus.wm_valid;
            bus.wm_ready = bus.in_ready;
        end
        accept = bus.in_valid && bus.in_ready;
    end

    // Geometry of the beat being offered; a sof always places it at 0,0.
    always_comb begin
        at_origin = (col == '0) && (row == '0);
        pos_col   = bus.in_sof ? '0 : col;
        pos_row   = bus.in_sof ? '0 : row;
        last_col  = (pos_col == LAST_COL);
        row_end   = bus.in_eol || last_col;
        frame_end = row_end && (pos_row == LAST_ROW);
        geo_bad   = (bus.in_eol != last_col) || (bus.in_sof && !at_origin);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_sum
        assign in_sum[l] = SW'(bus.in_data[l*PW + CH_R*DW +: DW])
                         + SW'(bus.in_data[l*PW + CH_G*DW +: DW])
                         + SW'(bus.in_data[l*PW + CH_B*DW +: DW]);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            run         <= 1'b0;
            active_mode <= WM_BYPASS;
            col         <= '0;
            row         <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
            run <= 1'b1;
            if (accept) begin
                if (bus.in_sof) active_mode <= wm_mode_e'(bus.cfg_mode);
                if (frame_end) begin
                    col <= '0;
                    row <= '0;
                end else if (row_end) begin
                    col <= '0;
                    row <= pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
                if (geo_bad)         err_q <= 1'b1;
                else if (bus.in_sof) err_q <= 1'b0;
            end
        end
    end

    // S1: capture the beat, its watermark bits, corrected markers and channel sums.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: payload registers are reset as well because out_data/out_avg must read 0 in reset.
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_wm    <= '0;
            s1_sum   <= '0;
            s1_mode  <= WM_BYPASS;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_wm    <= (beat_mode == WM_BYPASS) ? '0 : bus.wm_data;
            s1_sum   <= in_sum;
            s1_mode  <= beat_mode;
            s1_sof   <= bus.in_sof;
            s1_eol   <= row_end;
            s1_eof   <= frame_end;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        wm_lane_embed #(.DW(DW)) u_lane (
            .mode    (s1_mode),
            .pix     (s1_data[l*PW +: PW]),
            .w       (s1_wm[l]),
            .sum     (s1_sum[l]),
            .pix_out (emb_data[l*PW +: PW]),
            .avg     (emb_avg[l*DW +: DW])
        );
    end

    // S2: output register, held while the sink stalls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_avg   <= '0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= s2_valid && bus.out_ready && s2_eof;
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= emb_data;
                    s2_avg  <= emb_avg;
                    s2_sof  <= s1_sof;
                    s2_eol  <= s1_eol;
                    s2_eof  <= s1_eof;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_avg   = s2_avg;
    assign bus.out_sof   = s2_sof;
    assign bus.out_eol   = s2_eol;
    assign bus.out_eof   = s2_eof;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_wm_stream_embed.sv
// Scoreboard bench for wm_stream_embed: a driver pushes expected beats computed from
// the embedding rules, and an independent monitor pops and compares on each output handshake.
module tb_wm_stream_embed;
    localparam int DW     = 8;
    localparam int LANES  = 2;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int COLS   = WIDTH / LANES;
    localparam int BEATS  = COLS * HEIGHT;

    typedef struct {
        logic [47:0] data;
        logic [15:0] avg;
        logic        sof, eol, eof;
        int          acc_cycle;
    } exp_t;

    logic HCLK;
    logic HRESETn;
    wm_stream_embed_if #(.DW(DW), .LANES(LANES)) bus ();

    wm_stream_embed #(.DW(DW), .LANES(LANES), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    exp_t exp_q[$];
    int   m_col = 0, m_row = 0, m_mode = 0, exp_eof = 0, done_seen = 0;
    logic m_err = 1'b0;
    int   rdy_mode = 0;
    bit   lat_check = 1'b0;
    bit   wm_off = 1'b0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected output pixels and averages from the embedding rules, one lane at a time.
    function automatic exp_t model_beat(input int mode, input logic [47:0] d, input logic [1:0] w);
        exp_t e;
        e = '{default: '0};
        for (int l = 0; l < LANES; l++) begin
            int r, g, b, wb;
            r  = int'(d[l*24+16 +: 8]);
            g  = int'(d[l*24+8 +: 8]);
            b  = int'(d[l*24 +: 8]);
            wb = int'(w[l]);
            e.avg[l*8 +: 8] = 8'((r + g + b) / 3);
            case (mode)
                1: begin r = (r & 254) | wb; g = (g & 254) | wb; b = (b & 254) | wb; end
                2: b = (b & 254) | wb;
                3: g = (g & 254) | (wb ^ (r % 2) ^ (b % 2));
                default: ;
            endcase
            e.data[l*24 +: 24] = {8'(r), 8'(g), 8'(b)};
        end
        return e;
    endfunction

    // Frame-geometry rules applied to one accepted beat; pushes its expected output.
    task automatic model_accept(input logic sof, input logic eol, input logic [47:0] d,
                                input logic [1:0] w, input int bm);
        exp_t e;
        bit   bad, last, eor;
        bad = 1'b0;
        if (sof) begin
            if (m_col != 0 || m_row != 0) bad = 1'b1;
            m_col  = 0;
            m_row  = 0;
            m_mode = bm;
        end
        last = (m_col == COLS - 1);
        if (eol != last) bad = 1'b1;
        eor = eol || last;
        e = model_beat(bm, d, w);
        e.sof = sof;
        e.eol = eor;
        e.eof = eor && (m_row == HEIGHT - 1);
        e.acc_cycle = cycle;
        if (bad)      m_err = 1'b1;
        else if (sof) m_err = 1'b0;
        if (e.eof) exp_eof++;
        if (eor) begin
            m_col = 0;
            m_row = e.eof ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send_beat(input logic sof, input logic eol, input logic [47:0] d,
                             input logic [1:0] w, input int gap);
        int bm, waited;
        bit taken;
        bm = sof ? int'(bus.cfg_mode) : m_mode;
        if ($urandom_range(99) < gap) begin
            bus.in_valid = 1'b0;
            bus.wm_valid = 1'($urandom_range(1));
            @(negedge HCLK);
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        bus.in_data  = d;
        bus.wm_data  = w;
        waited = 0;
        taken  = 1'b0;
        while (!taken) begin
            if (bm == 0) bus.wm_valid = wm_off ? 1'b0 : 1'($urandom_range(1));
            else         bus.wm_valid = ($urandom_range(99) >= gap);
            #4;
            if (bm != 0 && !bus.wm_valid) check("in_ready_without_wm", 72'(bus.in_ready), 72'(0));
            if (bus.in_ready) begin
                check("wm_ready_on_accept", 72'(bus.wm_ready), 72'(bm != 0));
                model_accept(sof, eol, d, w, bm);
                taken = 1'b1;
            end else if (++waited > 300) begin
                check("accept_timeout", 72'(bus.in_ready), 72'(1));
                taken = 1'b1;
            end
            @(negedge HCLK);
        end
        bus.in_valid = 1'b0;
        bus.wm_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int gap, input bit fixed,
                             input logic [23:0] pix, input logic [1:0] wfix);
        logic [63:0] rnd;
        logic [1:0]  w;
        bus.cfg_mode = 2'(mode);
        for (int b = 0; b < BEATS; b++) begin
            rnd = {$urandom(), $urandom()};
            w   = fixed ? wfix : 2'($urandom_range(3));
            send_beat(b == 0, (b % COLS) == COLS - 1, fixed ? {pix, pix} : rnd[47:0], w, gap);
            if (b == 0) bus.cfg_mode = 2'($urandom_range(3));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge HCLK);
            n++;
        end
        check("drain_queue_empty", 72'(exp_q.size()), 72'(0));
        repeat (3) @(negedge HCLK);
    endtask

    // Sink: ready pattern chosen by the sequence.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge HCLK);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(99) < 60);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stall hold and done timing.
    initial begin
        exp_t        e;
        bit          prev_stall, prev_eof_hs;
        logic [67:0] prev_vec, cur_vec;
        prev_stall  = 1'b0;
        prev_eof_hs = 1'b0;
        prev_vec    = '0;
        forever begin
            @(negedge HCLK);
            #4;
            if (!HRESETn) begin
                prev_stall  = 1'b0;
                prev_eof_hs = 1'b0;
                continue;
            end
            cur_vec = {bus.out_valid, bus.out_data, bus.out_avg, bus.out_sof, bus.out_eol, bus.out_eof};
            if (prev_eof_hs || bus.done) check("done_after_eof", 72'(bus.done), 72'(prev_eof_hs));
            if (bus.done) done_seen++;
            if (prev_stall) check("stall_hold", 72'(cur_vec), 72'(prev_vec));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 72'(bus.out_valid), 72'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 72'(bus.out_data), 72'(e.data));
                    check("out_avg", 72'(bus.out_avg), 72'(e.avg));
                    check("sof_eol_eof", 72'({bus.out_sof, bus.out_eol, bus.out_eof}),
                          72'({e.sof, e.eol, e.eof}));
                    if (lat_check) check("latency", 72'(cycle - e.acc_cycle), 72'(2));
                end
            end
            prev_stall  = bus.out_valid && !bus.out_ready;
            prev_eof_hs = bus.out_valid && bus.out_ready && bus.out_eof;
            prev_vec    = cur_vec;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, 72'(bus.out_valid), 72'(0));
        check({tag, "_out_data"}, 72'(bus.out_data), 72'(0));
        check({tag, "_out_avg"}, 72'(bus.out_avg), 72'(0));
        check({tag, "_markers"}, 72'({bus.out_sof, bus.out_eol, bus.out_eof}), 72'(0));
        check({tag, "_done_err"}, 72'({bus.done, bus.err}), 72'(0));
        check({tag, "_ready"}, 72'({bus.in_ready, bus.wm_ready}), 72'(0));
    endtask

    initial begin
        logic [63:0] rnd;
        bus.cfg_mode = 2'd0;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        bus.in_eol   = 1'b0;
        bus.in_data  = '0;
        bus.wm_valid = 1'b1;
        bus.wm_data  = '0;
        HRESETn      = 1'b1;
        #1 HRESETn = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge HCLK);
        #2 HRESETn = 1'b1;
        #1 check("ready_before_first_edge", 72'(bus.in_ready), 72'(0));
        @(negedge HCLK);
        bus.in_valid = 1'b0;
        bus.wm_valid = 1'b0;

        // Directed embeds with an always-ready sink: R=0x10 G=0x21 B=0x33.
        lat_check = 1'b1;
        rdy_mode  = 0;
        run_frame(1, 0, 1'b1, 24'h102133, 2'b11);
        run_frame(2, 0, 1'b1, 24'h102133, 2'b00);
        wm_off = 1'b1;
        run_frame(0, 0, 1'b1, 24'h102133, 2'b11);
        wm_off = 1'b0;
        run_frame(3, 0, 1'b1, 24'h102133, 2'b01);
        run_frame(3, 0, 1'b1, 24'h102133, 2'b10);
        drain();
        check("err_clean", 72'(bus.err), 72'(m_err));
        lat_check = 1'b0;

        // Random frames with sink back-pressure and source / watermark gaps.
        rdy_mode = 1;
        for (int f = 0; f < 6; f++) run_frame($urandom_range(3), 30, 1'b0, 24'h0, 2'b00);
        drain();
        check("err_random_frames", 72'(bus.err), 72'(m_err));

        // Early eol on beat 0, then a stray sof; the stream resyncs from there.
        bus.cfg_mode = 2'd1;
        for (int b = 0; b < 5; b++) begin
            rnd = {$urandom(), $urandom()};
            send_beat(b < 2, (b == 0) || (b == 2) || (b == 4), rnd[47:0], 2'($urandom_range(3)), 20);
        end
        drain();
        check("err_after_bad_geometry", 72'(bus.err), 72'(m_err));
        run_frame(2, 20, 1'b0, 24'h0, 2'b00);
        drain();
        check("err_cleared_by_clean_sof", 72'(bus.err), 72'(m_err));

        // Fill S1 and S2 against a stalled sink, then reset mid-frame.
        rdy_mode = 2;
        bus.cfg_mode = 2'd2;
        rnd = {$urandom(), $urandom()};
        send_beat(1'b1, 1'b1, rnd[47:0], 2'b01, 0);
        rnd = {$urandom(), $urandom()};
        send_beat(1'b0, 1'b0, rnd[47:0], 2'b10, 0);
        @(negedge HCLK);
        check("stalled_full_out_valid", 72'(bus.out_valid), 72'(1));
        check("stalled_err", 72'(bus.err), 72'(m_err));
        bus.in_valid = 1'b1;
        bus.wm_valid = 1'b1;
        #2 HRESETn = 1'b0;
        #1 check_outputs_zero("midframe_reset");
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_mode = 0;
        m_err = 1'b0;
        bus.in_valid = 1'b0;
        bus.wm_valid = 1'b0;
        repeat (2) @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);
        rdy_mode = 1;
        run_frame(1, 20, 1'b0, 24'h0, 2'b00);
        run_frame(3, 20, 1'b0, 24'h0, 2'b00);
        drain();
        check("err_after_reset", 72'(bus.err), 72'(m_err));
        check("done_pulse_count", 72'(done_seen), 72'(exp_eof));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
